// File: rtl/branch_predictor_bht_pkg.sv
// ============================================================================
// branch_predictor_bht_pkg: branch-class codes, PC step and counter helpers
// shared by the BHT/BTB predictor. Also carries the shared 99_define.vh codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef BP_DEFINE_VH
`define BP_DEFINE_VH
`define NOTBRANCH  4'd0
`define BR_COND    4'd1
`define BR_JAL     4'd2
`define BR_JALR    4'd3
`define BP_PC_STEP 32'd4
`endif

package branch_predictor_bht_pkg;

   localparam logic [31:0] BP_PC_STEP = `BP_PC_STEP;

   typedef enum logic [3:0] {
      BRC_NONE = `NOTBRANCH,
      BRC_COND = `BR_COND,
      BRC_JAL  = `BR_JAL,
      BRC_JALR = `BR_JALR
   } br_class_e;

   // Counter encodings: the two values either side of the taken threshold.
   function automatic int ctr_weak_nt(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

   function automatic int ctr_weak_t(input int bits);
      return 1 << (bits - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_bht_sat_counter.sv
// ============================================================================
// bp_sat_counter: next-value logic of a CTR_BITS-wide saturating counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_sat_counter #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_q,
   input  logic                inc,
   input  logic                dec,
   output logic [CTR_BITS-1:0] ctr_d
);

   always_comb begin
      ctr_d = ctr_q;
      if (inc && !dec && (ctr_q != '1)) begin
         ctr_d = ctr_q + CTR_BITS'(1);
      end else if (dec && !inc && (ctr_q != '0)) begin
         ctr_d = ctr_q - CTR_BITS'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_bht.sv
// ============================================================================
// branch_predictor_bht: direct-mapped BHT+BTB predictor with decode-side
// success/failure check and training. Optional statistics: BP_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8,
   parameter int CTR_BITS   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   input  logic [31:0] pcD,
   input  logic [31:0] pred_pcD,
   input  logic [31:0] branch_pc,
   input  logic        branch_taken,
   input  logic [3:0]  info_branch,
   input  logic        stall,
   output logic        is_branch,
   output logic        success,
   output logic        failure,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_failures
);
   import branch_predictor_bht_pkg::*;

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT  = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_weak_t(CTR_BITS));

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f;
   logic [INDEX_BITS-1:0] idx_d;
   logic [TAG_BITS-1:0]   tag_f;
   logic [TAG_BITS-1:0]   tag_d;
   logic                  hit_d;
   logic                  train;
   logic [CTR_BITS-1:0]   ctr_sat;
   logic                  unused_pc_bits;

   assign idx_f = pcF[INDEX_BITS+1:2];
   assign tag_f = pcF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign idx_d = pcD[INDEX_BITS+1:2];
   assign tag_d = pcD[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign unused_pc_bits = &{1'b0, pcF, pcD};

   // Fetch-side lookup reads the registered table directly: no bypass.
   assign pred_hit     = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken   = pred_hit && ctr_q[idx_f][CTR_BITS-1];
   assign pred_next_pc = pred_taken ? target_q[idx_f] : (pcF + BP_PC_STEP);

   assign is_branch = (info_branch != `NOTBRANCH);
   assign success   = is_branch && (pred_pcD == branch_pc);
   assign failure   = is_branch && !success;

   assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
   assign train = is_branch && !stall;

   bp_sat_counter #(
      .CTR_BITS (CTR_BITS)
   ) u_sat_counter (
      .ctr_q (ctr_q[idx_d]),
      .inc   (branch_taken),
      .dec   (!branch_taken),
      .ctr_d (ctr_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            ctr_q[i]    <= CTR_INIT;
            target_q[i] <= '0;
         end
      end else if (train) begin
         if (hit_d) begin
            ctr_q[idx_d] <= ctr_sat;
            if (branch_taken) begin
               target_q[idx_d] <= branch_pc;
            end
         end else if (branch_taken) begin
            // A taken miss evicts whatever aliased into this slot.
            valid_q[idx_d]  <= 1'b1;
            tag_q[idx_d]    <= tag_d;
            ctr_q[idx_d]    <= CTR_ALLOC;
            target_q[idx_d] <= branch_pc;
         end
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] branch_cnt;
   logic [31:0] failure_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt  <= '0;
         failure_cnt <= '0;
      end else if (train) begin
         branch_cnt <= branch_cnt + 32'd1;
         if (failure) begin
            failure_cnt <= failure_cnt + 32'd1;
         end
      end
   end

   assign stat_branches = branch_cnt;
   assign stat_failures = failure_cnt;
`else
   assign stat_branches = '0;
   assign stat_failures = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// ============================================================================
// tb_branch_predictor_bht: table-driven, scoreboarded bench for the predictor.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef NOTBRANCH
`define NOTBRANCH 4'd0
`endif
`ifndef BR_COND
`define BR_COND 4'd1
`endif

module tb_branch_predictor_bht;

   typedef struct {
      logic [31:0] pcf;
      logic [31:0] pcd;
      logic [31:0] predd;
      logic [31:0] bpc;
      logic        tk;
      logic [3:0]  info;
      logic        stl;
      logic        e_hit;
      logic        e_tk;
      logic [31:0] e_npc;
      logic        e_isbr;
      logic        e_succ;
      logic        e_fail;
   } vec_t;

   typedef struct {
      int          id;
      logic        hit;
      logic        tk;
      logic [31:0] npc;
      logic        isbr;
      logic        succ;
      logic        fail;
      logic [31:0] sbr;
      logic [31:0] sfail;
   } exp_t;

   localparam int NVEC = 28;
   localparam logic [3:0] N = `NOTBRANCH;
   localparam logic [3:0] C = `BR_COND;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF, pcD, pred_pcD, branch_pc;
   logic        branch_taken, stall;
   logic [3:0]  info_branch;
   logic        pred_hit, pred_taken, is_branch, success, failure;
   logic [31:0] pred_next_pc, stat_branches, stat_failures;

   int checks   = 0;
   int failures = 0;
   vec_t vecs [NVEC];
   exp_t sb [$];
   logic [31:0] m_br = 0;
   logic [31:0] m_fail = 0;

   always #5 clk = ~clk;

   branch_predictor_bht dut (
      .clk           (clk),
      .rst           (rst),
      .pcF           (pcF),
      .pred_hit      (pred_hit),
      .pred_taken    (pred_taken),
      .pred_next_pc  (pred_next_pc),
      .pcD           (pcD),
      .pred_pcD      (pred_pcD),
      .branch_pc     (branch_pc),
      .branch_taken  (branch_taken),
      .info_branch   (info_branch),
      .stall         (stall),
      .is_branch     (is_branch),
      .success       (success),
      .failure       (failure),
      .stat_branches (stat_branches),
      .stat_failures (stat_failures)
   );

   function automatic vec_t mk(input logic [31:0] pcf, pcd, predd, bpc,
                               input logic tk, input logic [3:0] info,
                               input logic stl, e_hit, e_tk,
                               input logic [31:0] e_npc,
                               input logic e_isbr, e_succ, e_fail);
      vec_t v;
      v.pcf = pcf; v.pcd = pcd; v.predd = predd; v.bpc = bpc;
      v.tk = tk; v.info = info; v.stl = stl;
      v.e_hit = e_hit; v.e_tk = e_tk; v.e_npc = e_npc;
      v.e_isbr = e_isbr; v.e_succ = e_succ; v.e_fail = e_fail;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef BP_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic drive(input vec_t v);
      pcF = v.pcf; pcD = v.pcd; pred_pcD = v.predd; branch_pc = v.bpc;
      branch_taken = v.tk; info_branch = v.info; stall = v.stl;
   endtask

   task automatic check_front();
      exp_t e;
      string tag;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      tag = $sformatf("v%0d", e.id);
      chk({tag, "_pred_hit"},      {31'd0, pred_hit},   {31'd0, e.hit});
      chk({tag, "_pred_taken"},    {31'd0, pred_taken}, {31'd0, e.tk});
      chk({tag, "_pred_next_pc"},  pred_next_pc,        e.npc);
      chk({tag, "_is_branch"},     {31'd0, is_branch},  {31'd0, e.isbr});
      chk({tag, "_success"},       {31'd0, success},    {31'd0, e.succ});
      chk({tag, "_failure"},       {31'd0, failure},    {31'd0, e.fail});
      chk({tag, "_stat_branches"}, stat_branches,       e.sbr);
      chk({tag, "_stat_failures"}, stat_failures,       e.sfail);
   endtask

   initial begin
      // Entry 0 holds 0x100 (tag 1) until 0x200 (tag 2) aliases it out.
      vecs[0]  = mk(32'h100, 32'h0,   32'h0,   32'h0,   0, N, 0, 0, 0, 32'h104, 0, 0, 0);
      vecs[1]  = mk(32'h100, 32'h100, 32'h104, 32'h200, 1, N, 0, 0, 0, 32'h104, 0, 0, 0);
      vecs[2]  = mk(32'h100, 32'h100, 32'h104, 32'h200, 1, C, 0, 0, 0, 32'h104, 1, 0, 1);
      vecs[3]  = mk(32'h100, 32'h0,   32'h0,   32'h0,   0, N, 0, 1, 1, 32'h200, 0, 0, 0);
      vecs[4]  = mk(32'h100, 32'h100, 32'h200, 32'h200, 1, C, 0, 1, 1, 32'h200, 1, 1, 0);
      vecs[5]  = vecs[4];
      vecs[6]  = vecs[4];
      vecs[7]  = mk(32'h100, 32'h100, 32'h200, 32'h104, 0, C, 0, 1, 1, 32'h200, 1, 0, 1);
      vecs[8]  = vecs[7];
      vecs[9]  = mk(32'h100, 32'h0,   32'h0,   32'h0,   0, N, 0, 1, 0, 32'h104, 0, 0, 0);
      vecs[10] = mk(32'h100, 32'h100, 32'h104, 32'h104, 0, C, 0, 1, 0, 32'h104, 1, 1, 0);
      vecs[11] = vecs[10];
      vecs[12] = mk(32'h100, 32'h100, 32'h104, 32'h200, 1, C, 0, 1, 0, 32'h104, 1, 0, 1);
      vecs[13] = vecs[9];
      vecs[14] = vecs[12];
      vecs[15] = vecs[3];
      vecs[16] = mk(32'h200, 32'h0,   32'h0,   32'h0,   0, N, 0, 0, 0, 32'h204, 0, 0, 0);
      vecs[17] = mk(32'h200, 32'h200, 32'h204, 32'h300, 1, C, 0, 0, 0, 32'h204, 1, 0, 1);
      vecs[18] = vecs[0];
      vecs[19] = mk(32'h200, 32'h0,   32'h0,   32'h0,   0, N, 0, 1, 1, 32'h300, 0, 0, 0);
      vecs[20] = mk(32'h200, 32'h200, 32'h300, 32'h400, 1, C, 0, 1, 1, 32'h300, 1, 0, 1);
      vecs[21] = mk(32'h200, 32'h0,   32'h0,   32'h0,   0, N, 0, 1, 1, 32'h400, 0, 0, 0);
      vecs[22] = mk(32'h200, 32'h200, 32'h400, 32'h204, 0, C, 1, 1, 1, 32'h400, 1, 0, 1);
      vecs[23] = vecs[22];
      vecs[24] = vecs[22];
      vecs[25] = mk(32'h200, 32'h200, 32'h400, 32'h204, 0, C, 0, 1, 1, 32'h400, 1, 0, 1);
      vecs[26] = vecs[21];
      vecs[27] = mk(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, N, 0, 0, 0, 32'h0, 0, 0, 0);

      rst = 1'b1;
      drive(vecs[0]);
      @(negedge clk);
      #1;
      chk("reset_pred_hit",      {31'd0, pred_hit},   32'd0);
      chk("reset_pred_taken",    {31'd0, pred_taken}, 32'd0);
      chk("reset_pred_next_pc",  pred_next_pc,        32'h104);
      chk("reset_stat_branches", stat_branches,       32'd0);
      chk("reset_stat_failures", stat_failures,       32'd0);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         exp_t e;
         @(negedge clk);
         drive(vecs[i]);
         e.id = i; e.hit = vecs[i].e_hit; e.tk = vecs[i].e_tk; e.npc = vecs[i].e_npc;
         e.isbr = vecs[i].e_isbr; e.succ = vecs[i].e_succ; e.fail = vecs[i].e_fail;
         e.sbr = stat_exp(m_br); e.sfail = stat_exp(m_fail);
         sb.push_back(e);
         if (vecs[i].e_isbr && !vecs[i].stl) begin
            m_br++;
            if (vecs[i].e_fail) m_fail++;
         end
         #1;
         check_front();
      end

      // Reset asserted across a training edge: the allocation must not land.
      @(negedge clk);
      drive(mk(32'h104, 32'h104, 32'h108, 32'h800, 1, C, 0, 0, 0, 32'h0, 0, 0, 0));
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      drive(mk(32'h104, 32'h0, 32'h0, 32'h0, 0, N, 0, 0, 0, 32'h0, 0, 0, 0));
      #1;
      chk("midrst_pred_hit",      {31'd0, pred_hit}, 32'd0);
      chk("midrst_pred_next_pc",  pred_next_pc,      32'h108);
      chk("midrst_stat_branches", stat_branches,     32'd0);
      chk("midrst_stat_failures", stat_failures,     32'd0);
      @(negedge clk);
      pcF = 32'h200;
      #1;
      chk("midrst_old_entry_hit", {31'd0, pred_hit}, 32'd0);
      chk("midrst_old_entry_npc", pred_next_pc,      32'h204);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised dynamic branch predictor. It is the next generation of the decode-stage success/failure checker.
- Fetch side: a direct-mapped table of saturating counters plus a branch target buffer (BHT+BTB) supplies the predicted next PC for pcF.
- Decode/resolve side: compares the carried prediction against the resolved target, raises success/failure/is_branch, and trains the table on the clock edge.
- Placed between the fetch PC mux and the decode-stage branch unit.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8, partial tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; INDEX_BITS+TAG_BITS <= 30.
- CTR_BITS, 2, saturating counter width (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcF  in  32  fetch PC to predict.
- pred_hit  out  1  valid entry with matching tag for pcF.
- pred_taken  out  1  pred_hit & counter MSB.
- pred_next_pc  out  32  pred_taken ? stored target : pcF+4.
- pcD  in  32  PC of the instruction in decode (resolving branch).
- pred_pcD  in  32  pred_next_pc carried down the pipeline with pcD.
- branch_pc  in  32  resolved next PC.
- branch_taken  in  1  resolved direction.
- info_branch  in  4  branch class; `NOTBRANCH = not a branch.
- stall  in  1  decode stalled; blocks training.
- is_branch  out  1  info_branch != `NOTBRANCH.
- success  out  1  is_branch & (pred_pcD == branch_pc).
- failure  out  1  is_branch & ~success.
- stat_branches  out  32  resolved-branch count (see Optional Feature).
- stat_failures  out  32  misprediction count (see Optional Feature).

Behaviour:
- Entry fields: valid, tag[TAG_BITS], ctr[CTR_BITS], target[32]. Storage is a register array with asynchronous read.
- Lookup is combinational with 0-cycle latency. is_branch, success and failure are combinational.
- Reset (async, any time, including mid-update):
  - all valid bits cleared; all ctr = 2^(CTR_BITS-1)-1 (weakly not-taken); targets = 0.
  - With no valid entries: pred_hit=0, pred_taken=0, pred_next_pc=pcF+4.
  - Stat counters are 0 in reset.
- Training occurs at the rising edge when is_branch & ~stall & ~rst.
  - Hit on pcD, taken: ctr = min(ctr+1, 2^CTR_BITS-1); target = branch_pc.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate (overwrites any prior occupant): valid=1, tag=pcD tag, ctr = 2^(CTR_BITS-1) (weakly taken), target = branch_pc.
  - Miss, not taken: no change.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass). The new value is visible on the next cycle.
- Counters saturate; they never wrap. pcF+4 wraps modulo 2^32.
- A stalled branch trains exactly once, in the first non-stalled cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments on every training event.
  - stat_failures increments when failure is also set.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- 99_define.vh (shared): existing `NOTBRANCH and branch-class codes; add the BP_PC_STEP (4) constant.
- Counter reset/init values derive from CTR_BITS inside the module.
- One sub-module is natural: bp_sat_counter (CTR_BITS parameter; inputs inc, dec; output next value with saturation), instantiated in the update path.

Test Plan:
- Reset, then pcF=0x100: pred_hit=0, pred_taken=0, pred_next_pc=0x104. Assert rst mid-training: the entry remains invalid afterwards.
- Taken-branch allocation: pcD=0x100, branch_pc=0x200, taken, info_branch≠`NOTBRANCH, pred_pcD=0x104.
  - Same cycle: failure=1.
  - Next cycle with pcF=0x100: pred_hit=1, pred_taken=1, pred_next_pc=0x200.
- Saturation (CTR_BITS=2), on a hit entry at 0x100:
  - 3 taken trainings: ctr=3 (no wrap).
  - Then 2 not-taken trainings: ctr=1, pred_taken=0, pred_next_pc=0x104.
  - Then 2 more not-taken trainings: ctr stays 0.
- Alias/tag: train 0x100 taken, then pcF=0x100+(1<<(INDEX_BITS+2)) gives pred_hit=0. A taken training at the aliasing PC replaces the entry; 0x100 then misses.
- Same-index update and lookup in one cycle: the lookup shows the old target; the next cycle shows the new one. With stall=1 for 3 cycles, then 0, the entry is trained once and stat_branches=1.
- Non-branch (info_branch=`NOTBRANCH) with pred_pcD≠branch_pc: is_branch=0, success=0, failure=0, no table change. With BP_STATS_EN defined, 5 branches with 2 mispredicts give stat_branches=5, stat_failures=2. With it undefined, both read 0.
